rf_scoreboard: RTL and testbench

- Parametrised successor to the 16x16 two-read/one-write register file.
- Generalised in data width, register count and number of read ports.
- Adds three behaviours: optional write-to-read bypass, optional hardwired-zero register 0, and a per-register outstanding-write scoreboard (saturating counter).
- The decode stage uses it to read operands, detect RAW hazards and claim destinations; the writeback stage retires claims.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_entry.sv | 57 +++++
 rtl/rf_scoreboard.sv | 99 +++++++++
 tb/tb_rf_scoreboard.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: default parameters and the depth helper shared by the register
// file scoreboard and its per-register entries.
package rf_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_RD_DEF   = 2;
  localparam int CNT_W_DEF    = 2;
  localparam int BYPASS_DEF   = 1;
  localparam int ZERO_REG_DEF = 1;

  // Number of registers addressed by an addr_w-bit address.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_entry.sv
// rf_entry: one register of the scoreboard register file.
// Holds the data word and a saturating count of outstanding (claimed but not
// yet written back) writes.
// Ports:
//   clk, rst     clock, async active-high reset
//   i_wr_hit     write targets this entry this cycle
//   i_claim_hit  claim targets this entry this cycle
//   i_wr_data    write data
//   o_data       stored data
//   o_cnt        outstanding-write count
//   o_busy       count is nonzero
module rf_entry #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_hit,
  input  logic              i_claim_hit,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_wr_hit) begin
      r_data <= i_wr_data;
    end
  end

  // Claim and write together cancel; that also covers a claim at max, which
  // is accepted because the net change is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({i_claim_hit, i_wr_hit})
        2'b10: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        2'b01: if (r_cnt != '0)      r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data = r_data;
  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised multi-read register file with optional
// write-to-read bypass, optional hardwired-zero register 0 and a per-register
// outstanding-write scoreboard.
// Ports:
//   clk, rst    clock, async active-high reset
//   rd_addr     NUM_RD packed read addresses
//   rd_data     NUM_RD packed read data (combinational)
//   rd_busy     per read port: addressed register has outstanding writes
//   wr_en/wr_addr/wr_data   writeback port (also retires one claim)
//   claim_en/claim_addr     destination claim from decode
//   claim_full  claim_addr counter is saturated; a claim now would be dropped
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_full
);

  localparam int               DEPTH   = rf_depth(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] w_data [DEPTH];
  logic [CNT_W-1:0]  w_cnt  [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic [DEPTH-1:0]  w_wr_hit;
  logic [DEPTH-1:0]  w_claim_hit;

  genvar r, p;

  generate
    for (r = 0; r < DEPTH; r++) begin : g_entry
      // Register 0 under ZERO_REG never sees a write or claim, so it stays
      // at its reset value of zero.
      localparam bit IS_ZERO = (ZERO_REG != 0) && (r == 0);

      assign w_wr_hit[r]    = !IS_ZERO && wr_en    && (wr_addr    == ADDR_W'(r));
      assign w_claim_hit[r] = !IS_ZERO && claim_en && (claim_addr == ADDR_W'(r));

      rf_entry #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_entry (
        .clk         (clk),
        .rst         (rst),
        .i_wr_hit    (w_wr_hit[r]),
        .i_claim_hit (w_claim_hit[r]),
        .i_wr_data   (wr_data),
        .o_data      (w_data[r]),
        .o_cnt       (w_cnt[r]),
        .o_busy      (w_busy[r])
      );
    end
  endgenerate

  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_is_zero;
      logic              w_byp;

      assign w_addr    = rd_addr[p*ADDR_W +: ADDR_W];
      assign w_is_zero = (ZERO_REG != 0) && (w_addr == '0);
      assign w_byp     = (BYPASS != 0) && wr_en && (wr_addr == w_addr);

      assign rd_data[p*DATA_W +: DATA_W] =
        w_is_zero ? '0 : (w_byp ? wr_data : w_data[w_addr]);

      // A same-cycle writeback retires one claim: the register only stays
      // busy if more than one write was outstanding.
      assign rd_busy[p] = !w_is_zero && w_busy[w_addr] &&
                          !(w_byp && (w_cnt[w_addr] == CNT_W'(1)));
    end
  endgenerate

  logic w_claim_zero;
  logic w_claim_wr;

  assign w_claim_zero = (ZERO_REG != 0) && (claim_addr == '0);
  assign w_claim_wr   = wr_en && (wr_addr == claim_addr);
  assign claim_full   = !w_claim_zero && !w_claim_wr &&
                        (w_cnt[claim_addr] == CNT_MAX);

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic        claim_full;

  rf_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .claim_full (claim_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  busy;
    logic        full;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are stable by the falling edge; compare whatever the
  // stimulus side queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "d0",   {16'h0, rd_data[15:0]},  {16'h0, e.d0});
        cmp(e.name, "d1",   {16'h0, rd_data[31:16]}, {16'h0, e.d1});
        cmp(e.name, "busy", {30'h0, rd_busy},        {30'h0, e.busy});
        cmp(e.name, "full", {31'h0, claim_full},     {31'h0, e.full});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a0, input logic [3:0] a1,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic ce, input logic [3:0] ca);
    rd_addr    = {a1, a0};
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    claim_en   = ce;
    claim_addr = ca;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [1:0] busy,
                            input logic full);
    exp_t e;
    e.name = nm; e.d0 = d0; e.d1 = d1; e.busy = busy; e.full = full;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    step();
    expect_out("reset", 16'h0, 16'h0, 2'b00, 1'b0);
    step();
    rst = 1'b0;
    // write reg3, bypassed to port0 in the same cycle
    drive(4'd3, 4'd5, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0);
    expect_out("wr3_bypass", 16'hBEEF, 16'h0000, 2'b00, 1'b0);
    step();
    drive(4'd3, 4'd3, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    expect_out("rd3_both", 16'hBEEF, 16'hBEEF, 2'b00, 1'b0);
    // register 0 is hardwired
    step();
    drive(4'd0, 4'd0, 1'b1, 4'd0, 16'h1234, 1'b1, 4'd0);
    expect_out("zero_wr", 16'h0, 16'h0, 2'b00, 1'b0);
    step();
    drive(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    expect_out("zero_after", 16'h0, 16'h0, 2'b00, 1'b0);
    // saturate reg5
    step();
    drive(4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
    expect_out("claim5_1", 16'h0, 16'h0, 2'b00, 1'b0);
    step();
    expect_out("claim5_2", 16'h0, 16'h0, 2'b11, 1'b0);
    step();
    expect_out("claim5_3", 16'h0, 16'h0, 2'b11, 1'b0);
    step();
    expect_out("claim5_4_drop", 16'h0, 16'h0, 2'b11, 1'b1);
    step();
    drive(4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd5);
    expect_out("full5_idle", 16'h0, 16'h0, 2'b11, 1'b1);
    step();
    drive(4'd5, 4'd5, 1'b1, 4'd5, 16'h1111, 1'b0, 4'd5);
    expect_out("wr5_1", 16'h1111, 16'h1111, 2'b11, 1'b0);
    step();
    drive(4'd5, 4'd5, 1'b1, 4'd5, 16'h2222, 1'b0, 4'd5);
    expect_out("wr5_2", 16'h2222, 16'h2222, 2'b11, 1'b0);
    step();
    drive(4'd5, 4'd5, 1'b1, 4'd5, 16'h3333, 1'b0, 4'd5);
    expect_out("wr5_3", 16'h3333, 16'h3333, 2'b00, 1'b0);
    step();
    drive(4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd5);
    expect_out("rd5_idle", 16'h3333, 16'h3333, 2'b00, 1'b0);
    // reg7 to max, then claim+write together
    step();
    drive(4'd7, 4'd3, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    expect_out("claim7_1", 16'h0, 16'hBEEF, 2'b00, 1'b0);
    step();
    expect_out("claim7_2", 16'h0, 16'hBEEF, 2'b01, 1'b0);
    step();
    expect_out("claim7_3", 16'h0, 16'hBEEF, 2'b01, 1'b0);
    step();
    drive(4'd7, 4'd7, 1'b1, 4'd7, 16'hA5A5, 1'b1, 4'd7);
    expect_out("cw7", 16'hA5A5, 16'hA5A5, 2'b11, 1'b0);
    step();
    drive(4'd7, 4'd7, 1'b0, 4'd0, 16'h0, 1'b0, 4'd7);
    expect_out("cw7_after", 16'hA5A5, 16'hA5A5, 2'b11, 1'b1);
    // write with no outstanding claim
    step();
    drive(4'd9, 4'd9, 1'b1, 4'd9, 16'h0909, 1'b0, 4'd9);
    expect_out("wr9", 16'h0909, 16'h0909, 2'b00, 1'b0);
    step();
    drive(4'd9, 4'd9, 1'b0, 4'd0, 16'h0, 1'b0, 4'd9);
    expect_out("wr9_after", 16'h0909, 16'h0909, 2'b00, 1'b0);
    // async reset between edges
    step();
    drive(4'd7, 4'd3, 1'b0, 4'd0, 16'h0, 1'b0, 4'd7);
    expect_out("pre_rst", 16'hA5A5, 16'hBEEF, 2'b01, 1'b1);
    step();
    #1;
    rst = 1'b1;
    expect_out("async_rst", 16'h0, 16'h0, 2'b00, 1'b0);
    step();
    drive(4'd7, 4'd9, 1'b1, 4'd3, 16'hFFFF, 1'b1, 4'd3);
    expect_out("in_rst", 16'h0, 16'h0, 2'b00, 1'b0);
    step();
    rst = 1'b0;
    drive(4'd3, 4'd7, 1'b0, 4'd0, 16'h0, 1'b0, 4'd3);
    expect_out("post_rst", 16'h0, 16'h0, 2'b00, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
